// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int DMEM_DEPTH = 64;
  localparam int CNT_W      = 4;

  function automatic logic misaligned(input logic [1:0] lsb);
    return (lsb != 2'b00);
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response bus between a requester and dmem_responder.
// The be lanes exist only when DMEM_BYTE_WRITE_EN is defined.
interface dmem_if;
  logic        req;
  logic        we;
  logic [7:0]  addr;
  logic [31:0] wdata;
`ifdef DMEM_BYTE_WRITE_EN
  logic [3:0]  be;
`endif
  logic [31:0] rdata;
  logic        ack;
  logic        err;

`ifdef DMEM_BYTE_WRITE_EN
  modport master (output req, we, addr, wdata, be, input rdata, ack, err);
  modport slave  (input req, we, addr, wdata, be, output rdata, ack, err);
`else
  modport master (output req, we, addr, wdata, input rdata, ack, err);
  modport slave  (input req, we, addr, wdata, output rdata, ack, err);
`endif
endinterface

// File: rtl/dmem_array.sv
// Word storage with per-lane synchronous write and a registered read port.
// Memory contents are deliberately not reset; only the read register is.
module dmem_array #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic          rd_en,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  input  logic [3:0]    lane_en,
  output logic [31:0]   rdata
);

  logic [31:0] mem_r [DEPTH];
  logic [31:0] rdata_r;

  // lane-masked write into the array
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) begin
          mem_r[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // read register, holds until the next enabled read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= 32'h0000_0000;
    end else if (rd_en) begin
      rdata_r <= mem_r[idx];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/dmem_responder.sv
// Single-port data-memory responder: IDLE/BUSY/RESP FSM with programmable wait.
// Optional byte-lane writes are enabled by defining DMEM_BYTE_WRITE_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int DEPTH       = DMEM_DEPTH
) (
  input  logic clk,
  input  logic rst_n,
  dmem_if.slave bus
);

  localparam int AW     = $clog2(DEPTH);
  localparam int LOAD_I = (WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0;
  localparam logic [CNT_W-1:0] CNT_LOAD = LOAD_I[CNT_W-1:0];

  state_e           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             capture_s, commit_s;
  logic             cap_we_r;
  logic [7:0]       cap_addr_r;
  logic [31:0]      cap_wdata_r;
  logic             ack_r, err_r;
  logic             fld_we_s;
  logic [7:0]       fld_addr_s;
  logic [31:0]      fld_wdata_s;
  logic [3:0]       lane_s;
  logic             mis_s;

  // On a zero-wait hop IDLE->RESP the commit edge is also the capture edge,
  // so the live inputs (exactly what is being captured) feed the array.
  assign fld_we_s    = (state_r == IDLE) ? bus.we    : cap_we_r;
  assign fld_addr_s  = (state_r == IDLE) ? bus.addr  : cap_addr_r;
  assign fld_wdata_s = (state_r == IDLE) ? bus.wdata : cap_wdata_r;
  assign mis_s       = misaligned(fld_addr_s[1:0]);

`ifdef DMEM_BYTE_WRITE_EN
  logic [3:0] cap_be_r;

  // byte-enable capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_be_r <= 4'b0000;
    end else if (capture_s) begin
      cap_be_r <= bus.be;
    end
  end

  assign lane_s = (state_r == IDLE) ? bus.be : cap_be_r;
`else
  assign lane_s = 4'b1111;
`endif

  // next-state and counter logic
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    capture_s = 1'b0;
    commit_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.req) begin
          capture_s = 1'b1;
          if (mis_s || (WAIT_CYCLES == 0)) begin
            state_s  = RESP;
            commit_s = 1'b1;
          end else begin
            state_s = BUSY;
            cnt_s   = CNT_LOAD;
          end
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_s  = RESP;
          commit_s = 1'b1;
        end else begin
          cnt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      RESP: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        cnt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // state, counter, capture and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      cap_we_r    <= 1'b0;
      cap_addr_r  <= 8'h00;
      cap_wdata_r <= 32'h0000_0000;
      ack_r       <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      if (capture_s) begin
        cap_we_r    <= bus.we;
        cap_addr_r  <= bus.addr;
        cap_wdata_r <= bus.wdata;
      end
      ack_r <= (state_r == RESP);
      err_r <= (state_r == RESP) && misaligned(cap_addr_r[1:0]);
    end
  end

  dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (commit_s && fld_we_s && !mis_s),
    .rd_en  (commit_s && !fld_we_s && !mis_s),
    .idx    (fld_addr_s[2 +: AW]),
    .wdata  (fld_wdata_s),
    .lane_en(lane_s),
    .rdata  (bus.rdata)
  );

  assign bus.ack = ack_r;
  assign bus.err = err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder at WAIT_CYCLES = 0, 1 and 3.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_n_w3 = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_if if_w0 ();
  dmem_if if_w1 ();
  dmem_if if_w3 ();

  dmem_responder #(.WAIT_CYCLES(0)) u_w0 (.clk(clk), .rst_n(rst_n),    .bus(if_w0.slave));
  dmem_responder #(.WAIT_CYCLES(1)) u_w1 (.clk(clk), .rst_n(rst_n),    .bus(if_w1.slave));
  dmem_responder #(.WAIT_CYCLES(3)) u_w3 (.clk(clk), .rst_n(rst_n_w3), .bus(if_w3.slave));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic idle_bus(virtual dmem_if vif);
    vif.req = 1'b0; vif.we = 1'b0; vif.addr = 8'h00; vif.wdata = 32'h0;
`ifdef DMEM_BYTE_WRITE_EN
    vif.be = 4'h0;
`endif
  endtask

  // one complete transaction; mutate rewrites addr/wdata right after capture
  task automatic do_txn(virtual dmem_if vif, input logic wr, input logic [7:0] a,
                        input logic [31:0] d, input logic [3:0] b, input int exp_lat,
                        input logic exp_err, input logic [31:0] exp_rd,
                        input bit mutate, input string tag);
    int k;
    logic got;
    logic [31:0] rd;
    logic er;
    @(negedge clk);
    vif.we = wr; vif.addr = a; vif.wdata = d;
`ifdef DMEM_BYTE_WRITE_EN
    vif.be = b;
`endif
    vif.req = 1'b1;
    k = 0; got = 1'b0; rd = 32'h0; er = 1'b0;
    while (!got && k < 40) begin
      @(posedge clk); #1;
      if (mutate && k == 0) begin
        vif.addr = a ^ 8'h0C; vif.wdata = ~d;
      end
      if (vif.ack) begin
        got = 1'b1; rd = vif.rdata; er = vif.err;
      end else begin
        k++;
      end
    end
    vif.req = 1'b0;
    check_eq({tag, ".ack"}, {31'b0, got}, 32'd1);
    check_eq({tag, ".lat"}, k, exp_lat);
    check_eq({tag, ".err"}, {31'b0, er}, {31'b0, exp_err});
    check_eq({tag, ".rdata"}, rd, exp_rd);
    @(posedge clk); #1;
    check_eq({tag, ".ack_pulse"}, {30'b0, vif.ack, vif.err}, 32'd0);
  endtask

  initial begin
    int k;
    int prev;
    logic seen;
    logic [31:0] exp_rd;
    idle_bus(if_w0); idle_bus(if_w1); idle_bus(if_w3);
    #12;
    check_eq("rst.w1", {if_w1.rdata[30:0], if_w1.ack} | {31'b0, if_w1.err}, 32'd0);
    check_eq("rst.w3", {if_w3.rdata[30:0], if_w3.ack} | {31'b0, if_w3.err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; rst_n_w3 = 1'b1;

    // WAIT_CYCLES=1: basic write/read, write ack keeps rdata, misaligned accesses
    do_txn(if_w1, 1'b1, 8'h08, 32'hDEAD_BEEF, 4'hF, 2, 1'b0, 32'h0, 1'b0, "w1.wr08");
    do_txn(if_w1, 1'b0, 8'h08, 32'h0, 4'hF, 2, 1'b0, 32'hDEAD_BEEF, 1'b0, "w1.rd08");
    do_txn(if_w1, 1'b1, 8'h04, 32'h0101_0101, 4'hF, 2, 1'b0, 32'hDEAD_BEEF, 1'b0, "w1.wr04");
    do_txn(if_w1, 1'b0, 8'h05, 32'h0, 4'hF, 1, 1'b1, 32'hDEAD_BEEF, 1'b0, "w1.rd05");
    do_txn(if_w1, 1'b1, 8'h06, 32'hFFFF_FFFF, 4'hF, 1, 1'b1, 32'hDEAD_BEEF, 1'b0, "w1.wr06");
    do_txn(if_w1, 1'b0, 8'h04, 32'h0, 4'hF, 2, 1'b0, 32'h0101_0101, 1'b0, "w1.rd04");

    // lane writes: partial mask, then an empty mask that must change nothing
    do_txn(if_w1, 1'b1, 8'h10, 32'h1122_3344, 4'hF, 2, 1'b0, 32'h0101_0101, 1'b0, "w1.wr10");
    do_txn(if_w1, 1'b1, 8'h10, 32'hAABB_CCDD, 4'h5, 2, 1'b0, 32'h0101_0101, 1'b0, "w1.wr10be");
`ifdef DMEM_BYTE_WRITE_EN
    exp_rd = 32'h11BB_33DD;
`else
    exp_rd = 32'hAABB_CCDD;
`endif
    do_txn(if_w1, 1'b0, 8'h10, 32'h0, 4'hF, 2, 1'b0, exp_rd, 1'b0, "w1.rd10");
`ifdef DMEM_BYTE_WRITE_EN
    do_txn(if_w1, 1'b1, 8'h10, 32'h0, 4'h0, 2, 1'b0, exp_rd, 1'b0, "w1.wr10be0");
    do_txn(if_w1, 1'b0, 8'h10, 32'h0, 4'hF, 2, 1'b0, exp_rd, 1'b0, "w1.rd10b");
`endif

    // WAIT_CYCLES=0: fill four words, then stream reads with req held high
    for (int i = 0; i < 4; i++)
      do_txn(if_w0, 1'b1, 8'(4 * i), 32'hA000_0000 + i, 4'hF, 1, 1'b0, 32'h0, 1'b0, "w0.fill");
    @(negedge clk);
    if_w0.we = 1'b0; if_w0.addr = 8'h00; if_w0.req = 1'b1;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      k = 0; seen = 1'b0;
      while (!seen && k < 20) begin
        @(posedge clk); #1; k++;
        seen = if_w0.ack;
      end
      check_eq("w0.b2b.ack", {31'b0, seen}, 32'd1);
      check_eq("w0.b2b.rdata", if_w0.rdata, 32'hA000_0000 + i);
      if (i > 0) check_eq("w0.b2b.period", cyc - prev, 32'd2);
      prev = cyc;
      if (i < 3) if_w0.addr = 8'(4 * (i + 1));
      else if_w0.req = 1'b0;
    end

    // WAIT_CYCLES=3: reset in BUSY aborts the write and clears rdata
    do_txn(if_w3, 1'b1, 8'h20, 32'h5555_AAAA, 4'hF, 4, 1'b0, 32'h0, 1'b0, "w3.wr20");
    do_txn(if_w3, 1'b0, 8'h20, 32'h0, 4'hF, 4, 1'b0, 32'h5555_AAAA, 1'b0, "w3.rd20");
    @(negedge clk);
    if_w3.we = 1'b1; if_w3.addr = 8'h20; if_w3.wdata = 32'h1234_5678; if_w3.req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n_w3 = 1'b0; if_w3.req = 1'b0;
    #1;
    check_eq("w3.rst.rdata", if_w3.rdata, 32'h0);
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      seen = seen | if_w3.ack | if_w3.err;
    end
    check_eq("w3.rst.noack", {31'b0, seen}, 32'd0);
    @(negedge clk);
    rst_n_w3 = 1'b1;
    do_txn(if_w3, 1'b0, 8'h20, 32'h0, 4'hF, 4, 1'b0, 32'h5555_AAAA, 1'b0, "w3.rd20post");

    // inputs changed after capture must not leak into the transaction
    do_txn(if_w3, 1'b1, 8'h28, 32'h2828_2828, 4'hF, 4, 1'b0, 32'h5555_AAAA, 1'b0, "w3.wr28");
    do_txn(if_w3, 1'b1, 8'h24, 32'hCAFE_F00D, 4'hF, 4, 1'b0, 32'h5555_AAAA, 1'b1, "w3.wr24mut");
    do_txn(if_w3, 1'b0, 8'h24, 32'h0, 4'hF, 4, 1'b0, 32'hCAFE_F00D, 1'b1, "w3.rd24mut");
    do_txn(if_w3, 1'b0, 8'h28, 32'h0, 4'hF, 4, 1'b0, 32'h2828_2828, 1'b0, "w3.rd28");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1, extra cycles between request capture and ack (legal range 0..15).
REQ-002 SHALL have parameter DEPTH, default 64, number of 32-bit words; addr[7:2] indexes words.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req  input  1  requester holds high until ack.
REQ-006 SHALL have port we  input  1  1 = write, 0 = read; sampled with req.
REQ-007 SHALL have port addr  input  8  byte address.
REQ-008 SHALL have port wdata  input  32  write data.
REQ-009 SHALL have port be  input  4  byte-lane write enables, present only with DMEM_BYTE_WRITE_EN.
REQ-010 SHALL have port rdata  output  32  read data, valid while ack high, held until the next read ack.
REQ-011 SHALL have port ack  output  1  one-cycle completion pulse.
REQ-012 SHALL have port err  output  1  misaligned access flag, valid with ack.

Function
REQ-013 SHALL implement states IDLE, BUSY and RESP.
REQ-014 In IDLE with req=1, SHALL capture we, addr, wdata and be into internal registers.
REQ-015 From IDLE with req=1, SHALL go to RESP if WAIT_CYCLES=0 or on error, else go to BUSY and load the counter with WAIT_CYCLES-1.
REQ-016 In BUSY, SHALL decrement the counter each cycle and go to RESP on the cycle after the counter reads 0.
REQ-017 In RESP, SHALL assert ack=1 for exactly one cycle, then return to IDLE.
REQ-018 Latency from the req-sampling edge to ack high SHALL be WAIT_CYCLES+1 cycles.
REQ-019 Ignores req outside IDLE; if req is still high on return to IDLE, SHALL start a new transaction (back-to-back period WAIT_CYCLES+2 cycles).
REQ-020 A write SHALL commit to the array on the edge entering RESP, using the captured fields only.
REQ-021 A read SHALL load rdata on the edge entering RESP from the captured address.
REQ-022 A write ack SHALL leave rdata unchanged.
REQ-023 With captured addr[1:0]≠0, SHALL set err=1 with ack, perform no write and leave rdata unchanged.
REQ-024 err SHALL be 0 whenever ack=0.
REQ-025 Changes to inputs after capture SHALL have no effect on the transaction in flight.

Reset
REQ-026 rst_n low SHALL force state=IDLE, counter=0, ack=0, err=0, rdata=0, asynchronously.
REQ-027 Reset mid-transaction SHALL abort it; an uncommitted write SHALL never commit.
REQ-028 The array SHALL not be reset; its contents survive rst_n.

Configuration
REQ-029 SHALL provide macro DMEM_BYTE_WRITE_EN.
REQ-030 With DMEM_BYTE_WRITE_EN defined, the be port SHALL exist and a write SHALL update only lanes whose be bit is 1; be=0000 SHALL still ack with no change.
REQ-031 Without DMEM_BYTE_WRITE_EN, the be port SHALL be absent and every write SHALL update the full word.

Structure
REQ-032 Package dmem_pkg SHALL hold the state enum (IDLE/BUSY/RESP), the DEPTH default and the counter width constant.
REQ-033 Sub-module dmem_array SHALL hold the storage: synchronous write with lane enables and registered read port.
REQ-034 The FSM, capture registers and counter SHALL stay in dmem_responder.

Verification
REQ-035 Reset, WAIT_CYCLES=1: write addr=0x08 wdata=0xDEADBEEF, then read 0x08 -> each ack exactly 2 cycles after req sampled; rdata=0xDEADBEEF, err=0.
REQ-036 WAIT_CYCLES=0 with req held high over 4 reads of 0x00/0x04/0x08/0x0C -> ack every 2nd cycle, rdata in address order.
REQ-037 Read addr=0x05 -> ack with err=1; rdata keeps its prior value; a later write to 0x06 leaves word 1 unchanged.
REQ-038 DMEM_BYTE_WRITE_EN: word 0x11223344 at 0x10, then write be=0101 wdata=0xAABBCCDD -> read 0x11BB33DD.
REQ-039 WAIT_CYCLES=3: write 0x20 with rst_n pulsed low in BUSY -> ack never asserted; after reset, read 0x20 returns the old value.
REQ-040 Change addr/wdata during BUSY -> the transaction uses the captured values; the array is unaffected by the changed values.
